// File: rtl/encoder_pipe.sv
// Systematic (12,7) block encoder with valid/ready input and a small codeword FIFO.
// Per-word error mask is XOR'd into the codeword as it enters the FIFO.
module encoder_pipe #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       d,
  input  logic [11:0]      err_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [11:0]      cx,
  output logic [CNT_W-1:0] word_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [11:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [OCC_W-1:0] r_occ;
  logic [CNT_W-1:0] r_cnt;

  logic [4:0]  w_par;
  logic [11:0] w_cw;
  logic        w_push;
  logic        w_pop;

  // Parity bits chosen so the decoder's syndrome is all-zero on clean words
  always_comb begin
    w_par    = '0;
    w_par[0] = d[0] ^ d[1] ^ d[5] ^ d[6];
    w_par[1] = d[0] ^ d[2] ^ d[4] ^ d[5];
    w_par[2] = d[0] ^ d[1] ^ d[3] ^ d[5] ^ d[6];
    w_par[3] = d[0] ^ d[1] ^ d[3] ^ d[5] ^ d[6];
    w_par[4] = d[1] ^ d[3] ^ d[5] ^ d[6];
    w_cw     = {w_par, d} ^ err_mask;
  end

  assign in_ready   = (r_occ != OCC_W'(DEPTH));
  assign out_valid  = (r_occ != '0);
  assign w_push     = in_valid & in_ready;
  assign w_pop      = out_valid & out_ready;
  assign cx         = out_valid ? r_mem[r_head] : 12'h000;
  assign word_count = r_cnt;

  // Storage carries no reset; occupancy alone decides what is visible
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail] <= w_cw;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(1);
        r_cnt  <= r_cnt + CNT_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: tb/tb_encoder_pipe.sv
// Scoreboard bench for encoder_pipe: stimulus pushes hand-computed codewords,
// a negedge monitor checks handshake state and pops/compares delivered codewords.
module tb_encoder_pipe;

  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       d;
  logic [11:0]      err_mask;
  logic             out_valid;
  logic             out_ready;
  logic [11:0]      cx;
  logic [CNT_W-1:0] word_count;

  typedef struct {
    logic [11:0] cw;
    bit          clean;
  } exp_t;

  exp_t        q[$];
  int          checks   = 0;
  int          failures = 0;
  int          exp_cnt  = 0;
  int          popped   = 0;

  encoder_pipe #(.DEPTH(2), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .d          (d),
    .err_mask   (err_mask),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .cx         (cx),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Decoder-side syndrome: each bit recomputes one parity check over the codeword
  function automatic logic [4:0] syndrome(input logic [11:0] c);
    logic [4:0] s;
    s[0] = c[7]  ^ c[0] ^ c[1] ^ c[5] ^ c[6];
    s[1] = c[8]  ^ c[0] ^ c[2] ^ c[4] ^ c[5];
    s[2] = c[9]  ^ c[0] ^ c[1] ^ c[3] ^ c[5] ^ c[6];
    s[3] = c[10] ^ c[0] ^ c[1] ^ c[3] ^ c[5] ^ c[6];
    s[4] = c[11] ^ c[1] ^ c[3] ^ c[5] ^ c[6];
    return s;
  endfunction

  // Monitor: sample mid-cycle, compare against the scoreboard, pop on handshake
  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready", 32'(in_ready), 32'(q.size() != 2));
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      check("word_count", 32'(word_count), 32'(exp_cnt[CNT_W-1:0]));
      if (q.size() == 0) begin
        check("cx_idle", 32'(cx), 32'h000);
      end else begin
        check("cx", 32'(cx), 32'(q[0].cw));
        if (q[0].clean) check("syndrome", 32'(syndrome(cx)), 32'h0);
        if (out_ready && out_valid) begin
          void'(q.pop_front());
          popped++;
        end
      end
    end
  end

  task automatic send(input logic [6:0] dv, input logic [11:0] mv, input logic [11:0] exp_cw);
    int waited = 0;
    in_valid = 1'b1;
    d        = dv;
    err_mask = mv;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 200) begin
        check("send_timeout", 32'(waited), 32'd0);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    q.push_back('{cw: exp_cw, clean: (mv == 12'h000)});
    exp_cnt++;
    #1;
    in_valid = 1'b0;
    d        = 7'bx;
    err_mask = 12'bx;
  endtask

  task automatic drain();
    int waited = 0;
    out_ready = 1'b1;
    while (q.size() != 0 && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    #1;
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    d         = 7'bx;
    err_mask  = 12'bx;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_cx", 32'(cx), 32'h000);
    check("rst_count", 32'(word_count), 32'd0);
    @(posedge clk); #1;

    // Single clean word, then back-to-back words and single-bit data patterns
    send(7'h01, 12'h000, 12'h781);
    send(7'h00, 12'h000, 12'h000);
    send(7'h02, 12'h000, 12'hE82);
    send(7'h7F, 12'h000, 12'h67F);
    send(7'h04, 12'h000, 12'h104);
    send(7'h08, 12'h000, 12'hE08);
    send(7'h10, 12'h000, 12'h110);
    send(7'h20, 12'h000, 12'hFA0);
    send(7'h40, 12'h000, 12'hEC0);
    // Error injection on data and parity bits
    send(7'h01, 12'h001, 12'h780);
    send(7'h01, 12'h080, 12'h701);
    send(7'h7F, 12'h881, 12'hEFE);
    drain();

    // Backpressure: two fill the FIFO, third waits until out_ready returns
    out_ready = 1'b0;
    send(7'h7F, 12'h000, 12'h67F);
    send(7'h02, 12'h000, 12'hE82);
    @(negedge clk);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_count", 32'(word_count), 32'(exp_cnt));
    @(posedge clk); #1;
    fork
      send(7'h01, 12'h000, 12'h781);
      begin
        repeat (4) @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    drain();
    check("popped_so_far", 32'(popped), 32'd15);

    // One held word, then simultaneous push and pop keeps occupancy at 1
    out_ready = 1'b0;
    send(7'h02, 12'h000, 12'hE82);
    out_ready = 1'b1;
    send(7'h7F, 12'h000, 12'h67F);
    out_ready = 1'b0;
    @(negedge clk);
    check("pushpop_valid", 32'(out_valid), 32'd1);
    check("pushpop_ready", 32'(in_ready), 32'd1);
    drain();

    // Reset with two words buffered discards them and clears the counter
    out_ready = 1'b0;
    send(7'h20, 12'h000, 12'hFA0);
    send(7'h40, 12'h000, 12'hEC0);
    rst = 1'b1;
    q.delete();
    exp_cnt = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst2_out_valid", 32'(out_valid), 32'd0);
    check("rst2_cx", 32'(cx), 32'h000);
    check("rst2_count", 32'(word_count), 32'd0);
    check("rst2_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(7'h01, 12'h000, 12'h781);
    drain();
    @(negedge clk);
    check("final_count", 32'(word_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
